ct_addr_seq: RTL and testbench



---
 rtl/ct_addr_seq_if.sv | 37 +++
 rtl/ct_addr_seq.sv | 139 +++++++++++++
 tb/tb_ct_addr_seq.sv | 120 ++++++++++++
 3 files changed

// File: rtl/ct_addr_seq_if.sv
// ----------------------------------------------------------------------------
// ct_addr_seq_if
//   Serial fetch-loop signals between the control-and-timing address
//   sequencer and its neighbours (ROM stage, arithmetic stage, debug).
//
//   is    : serial instruction from ROM, LSB first
//   carry : serial carry from arithmetic stage (high = carry this bit time)
//   sync  : word sync, active-low during bit time 0
//   ia    : serial ROM address, LSB first
//   pc    : current program address (debug)
//
//   master : the sequencer side (drives sync/ia/pc, consumes is/carry)
//   slave  : the environment side (ROM, arithmetic stage, observers)
// ----------------------------------------------------------------------------
interface ct_addr_seq_if;
  logic       is;
  logic       carry;
  logic       sync;
  logic       ia;
  logic [7:0] pc;

  modport master (
    input  is,
    input  carry,
    output sync,
    output ia,
    output pc
  );

  modport slave (
    output is,
    output carry,
    input  sync,
    input  ia,
    input  pc
  );
endinterface

// File: rtl/ct_addr_seq.sv
// ----------------------------------------------------------------------------
// ct_addr_seq
//   Control-and-timing address sequencer. Generates the 56-bit-time word
//   framing, serially sends the 8-bit program address to the ROM stage at
//   bit times 19..26, shifts in the 10-bit instruction returned at bit times
//   45..54 and, on the last bit time (55), commits the next program address:
//   increment, call/return or carry-conditional branch.
//
//   Ports:
//     cph1 : system clock, all state changes on the rising edge
//     pon  : power-on reset, asynchronous, active-high
//     bus  : ct_addr_seq_if.master (is, carry in; sync, ia, pc out)
//
//   Build option:
//     CT_RET_EN : when defined, a single-level return register is kept;
//                 call (type 01) saves pc+1 and 10'h030 restores it.
//                 When undefined, call is a plain jump and 10'h030 is an
//                 ordinary increment.
// ----------------------------------------------------------------------------
module ct_addr_seq (
  input  logic          cph1,
  input  logic          pon,
  ct_addr_seq_if.master bus
);

  localparam logic [5:0] BT_LAST     = 6'd55;
  localparam logic [5:0] BT_IA_FIRST = 6'd19;
  localparam logic [5:0] BT_IA_LAST  = 6'd26;
  localparam logic [5:0] BT_IS_FIRST = 6'd45;
  localparam logic [5:0] BT_IS_LAST  = 6'd54;
  localparam logic [5:0] BT_CY_LAST  = 6'd44;

  localparam logic [9:0] INST_RET    = 10'h030;
  localparam logic [1:0] TYPE_CALL   = 2'b01;
  localparam logic [1:0] TYPE_BRANCH = 2'b11;

  logic [5:0] bt;
  logic [9:0] inst;
  logic [7:0] pc;
  logic       carry_f;
  logic       carry_p;

  logic       last_bt;
  logic       ia_win;
  logic       is_win;
  logic       cy_win;
  logic [5:0] ia_idx;
  logic [7:0] pc_inc;
  logic [7:0] pc_next;

`ifdef CT_RET_EN
  logic [7:0] ret;
  logic [7:0] ret_next;
`endif

  // --------------------------------------------------------------------------
  // Bit-time windows
  // --------------------------------------------------------------------------
  assign last_bt = (bt == BT_LAST);
  assign ia_win  = (bt >= BT_IA_FIRST) && (bt <= BT_IA_LAST);
  assign is_win  = (bt >= BT_IS_FIRST) && (bt <= BT_IS_LAST);
  assign cy_win  = (bt <= BT_CY_LAST);
  assign ia_idx  = bt - BT_IA_FIRST;
  assign pc_inc  = pc + 8'd1;

  // --------------------------------------------------------------------------
  // Outputs: all combinational from registered state, so they sit at their
  // reset values for as long as pon holds the registers cleared.
  // --------------------------------------------------------------------------
  assign bus.sync = (bt != 6'd0);
  assign bus.ia   = ia_win ? pc[ia_idx[2:0]] : 1'b0;
  assign bus.pc   = pc;

  // --------------------------------------------------------------------------
  // Next-address decode, evaluated from pre-commit values
  // --------------------------------------------------------------------------
  always_comb begin
    pc_next = pc_inc;
`ifdef CT_RET_EN
    ret_next = ret;
    if (inst == INST_RET) begin
      pc_next = ret;
    end else if (inst[1:0] == TYPE_CALL) begin
      ret_next = pc_inc;
      pc_next  = inst[9:2];
    end else if (inst[1:0] == TYPE_BRANCH) begin
      pc_next = carry_p ? pc_inc : inst[9:2];
    end
`else
    if (inst[1:0] == TYPE_CALL) begin
      pc_next = inst[9:2];
    end else if (inst[1:0] == TYPE_BRANCH) begin
      pc_next = carry_p ? pc_inc : inst[9:2];
    end
`endif
  end

  // --------------------------------------------------------------------------
  // Framing counter, instruction shifter, carry tracking, commit
  // --------------------------------------------------------------------------
  always_ff @(posedge cph1 or posedge pon) begin
    if (pon) begin
      bt      <= '0;
      inst    <= '0;
      pc      <= '0;
      carry_f <= 1'b0;
      carry_p <= 1'b0;
    end else begin
      bt <= last_bt ? '0 : bt + 6'd1;

      if (is_win) begin
        inst <= {bus.is, inst[9:1]};
      end

      // Clear on the last bit time wins over any carry seen on that edge.
      if (last_bt) begin
        carry_f <= 1'b0;
      end else if (cy_win) begin
        carry_f <= carry_f | bus.carry;
      end

      if (last_bt) begin
        pc      <= pc_next;
        carry_p <= carry_f;
      end
    end
  end

`ifdef CT_RET_EN
  always_ff @(posedge cph1 or posedge pon) begin
    if (pon) begin
      ret <= '0;
    end else if (last_bt) begin
      ret <= ret_next;
    end
  end
`endif

endmodule

// File: tb/tb_ct_addr_seq.sv
module tb_ct_addr_seq;

  logic cph1;
  logic pon;

  ct_addr_seq_if bus ();

  ct_addr_seq dut (
    .cph1 (cph1),
    .pon  (pon),
    .bus  (bus.master)
  );

  initial cph1 = 1'b0;
  always #5 cph1 = ~cph1;

  typedef struct {
    logic [9:0] inst;     // instruction returned by the "ROM" this word
    int         carry_bt; // bit time at which carry pulses (-1 = none)
    logic [7:0] exp_addr; // address expected on ia / pc during this word
  } vec_t;

  vec_t tbl[12];

  int n_vec;
  int n_miss;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Runs one word starting at a negedge where the DUT sits at bt==0.
  // Ends at the negedge of the next word's bt==0, or right after asserting
  // pon when abort_bt is reached.
  task automatic run_word(input vec_t v, input int abort_bt, input string tag);
    logic [7:0] addr;
    int sync_err;
    int idle_err;
    addr     = '0;
    sync_err = 0;
    idle_err = 0;
    for (int b = 0; b < 56; b++) begin
      if (bus.sync !== (b != 0)) sync_err++;
      if (b >= 19 && b <= 26) addr[b-19] = bus.ia;
      else if (bus.ia !== 1'b0) idle_err++;
      if (b == 30) chk({tag, " pc"}, bus.pc, v.exp_addr);
      if (b == abort_bt) begin
        pon = 1'b1;
        #1;
        chk({tag, " abort sync"}, bus.sync, 0);
        chk({tag, " abort ia"}, bus.ia, 0);
        chk({tag, " abort pc"}, bus.pc, 0);
        return;
      end
      // is is held high outside its window so stray bits would corrupt inst
      bus.is    = (b >= 45 && b <= 54) ? v.inst[b-45] : 1'b1;
      bus.carry = (b == v.carry_bt);
      @(negedge cph1);
    end
    chk({tag, " ia addr"}, addr, v.exp_addr);
    chk({tag, " sync frame errs"}, sync_err, 0);
    chk({tag, " ia idle errs"}, idle_err, 0);
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;

    tbl[0]  = '{10'h000, -1, 8'h00};
    tbl[1]  = '{10'h000, -1, 8'h01};
    tbl[2]  = '{10'h295, -1, 8'h02}; // jump/call to A5
    tbl[3]  = '{10'h041, -1, 8'hA5}; // jump/call to 10
    tbl[4]  = '{10'h0C1, -1, 8'h10}; // call 30
`ifdef CT_RET_EN
    tbl[5]  = '{10'h030, -1, 8'h30}; // return -> 11
    tbl[6]  = '{10'h000, 20, 8'h11}; // carry this word
    tbl[7]  = '{10'h203, 55, 8'h12}; // branch not taken; carry at 55 ignored
    tbl[8]  = '{10'h203, -1, 8'h13}; // branch taken -> 80
`else
    tbl[5]  = '{10'h030, -1, 8'h30}; // plain increment -> 31
    tbl[6]  = '{10'h000, 20, 8'h31};
    tbl[7]  = '{10'h203, 55, 8'h32};
    tbl[8]  = '{10'h203, -1, 8'h33};
`endif
    tbl[9]  = '{10'h3FD, -1, 8'h80}; // jump to FF
    tbl[10] = '{10'h000, -1, 8'hFF}; // wrap to 00
    tbl[11] = '{10'h041, -1, 8'h00}; // jump to 10

    pon       = 1'b1;
    bus.is    = 1'b0;
    bus.carry = 1'b0;
    repeat (3) @(negedge cph1);
    chk("reset sync", bus.sync, 0);
    chk("reset ia", bus.ia, 0);
    chk("reset pc", bus.pc, 0);
    pon = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_word(tbl[i], -1, $sformatf("w%0d", i));
    end

    // Call fetch at pc=10 aborted by pon at bit time 50.
    run_word('{10'h0C1, -1, 8'h10}, 50, "w12");
    repeat (3) @(negedge cph1);
    chk("post-abort pc", bus.pc, 0);
    chk("post-abort sync", bus.sync, 0);
    pon = 1'b0;

    run_word('{10'h000, -1, 8'h00}, -1, "w13");
    run_word('{10'h000, -1, 8'h01}, -1, "w14");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
